tile_gather_unit: RTL and testbench
===================================

// Module: tile_gather_unit
// PURPOSE
//  Parametrised multi-lane tile address generator plus operand gather for the systolic array feed path.
//  Per step, generates LANES bounded addresses and issues one banked scratchpad read per lane.
//  Zero-fills out-of-bound lanes and presents one packed LANES*DATA_W vector per step on a valid/ready stream.
//  Serves both the activation (im2col) feed and the weight feed. Sits between ConvController and the input/weight buffers.
// PARAMETERS
//  LANES   8   lanes per step (array width)
//  DATA_W  8   bits per gathered element
//  ADDR_W  17  scratchpad address width per lane
//  CNT_W   11  step counter width
// PORTS
//  clk              in   1             clock
//  rst              in   1             synchronous, active-low reset (0 = reset)
//  start            in   1             pulse; sample cfg_*, begin job (ignored unless IDLE)
//  abort            in   1             pulse; kill job, return to IDLE, no done
//  cfg_base         in   ADDR_W        address of lane 0, step 0
//  cfg_lane_stride  in   ADDR_W        address delta between adjacent lanes
//  cfg_step_stride  in   ADDR_W        address delta between steps
//  cfg_limit        in   ADDR_W        lane valid iff address < cfg_limit
//  cfg_steps        in   CNT_W         number of steps in job (0 allowed)
//  busy             out  1             job active
//  done             out  1             1-cycle pulse at job completion
//  mem_rd_en        out  LANES         per-lane read strobe
//  mem_rd_addr      out  LANES*ADDR_W  per-lane read address; lane i at [i*ADDR_W +: ADDR_W]
//  mem_rd_data      in   LANES*DATA_W  per-lane read data; fixed 1-cycle latency after mem_rd_en
//  out_valid        out  1             out_* hold a step
//  out_ready        in   1             consumer accepts
//  out_data         out  LANES*DATA_W  gathered vector; lane i at [i*DATA_W +: DATA_W]
//  out_lane_valid   out  LANES         lane in-bounds mask for this step
//  out_last         out  1             final step of job
//  out_step         out  CNT_W         step index of the presented vector
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; buffers empty.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE->RUN on start with cfg_steps>0.
//   IDLE with start and cfg_steps==0: done pulses next cycle, no beats.
//   RUN->DRAIN once all steps have been issued.
//   DRAIN->IDLE on the handshake of the out_last beat; done pulses the following cycle.
//  busy=1 in RUN/DRAIN. cfg_* are registered at start; later cfg changes have no effect on the running job.
//  Addressing: computed at width W=ADDR_W+CNT_W+1, no wrap.
//   step_base(0) = cfg_base; step_base(s+1) = step_base(s) + cfg_step_stride.
//   addr(i,s) = step_base(s) + i*cfg_lane_stride.
//   Lane valid iff addr < cfg_limit (zero-extended).
//   mem_rd_addr carries addr[ADDR_W-1:0]; mem_rd_en[i] = issue & valid(i,s). Invalid lanes never read.
//  Buffering: 2-entry output FIFO.
//   Issue a step only when (occupancy + in-flight) < 2, so out_ready stalls never drop or duplicate data.
//   Capture on the cycle after issue: data lane i = valid ? mem_rd_data lane i : 0. Mask, last and step index travel with the data.
//  Timing:
//   start at cycle T -> first mem_rd_en at T+1 -> out_valid at T+2.
//   With out_ready held 1, one beat per cycle.
//  Stream rules:
//   out_* stay stable while out_valid & !out_ready.
//   out_valid is never dropped without a handshake.
//   Beats are in step order.
//  abort (any state) or rst=0: next cycle IDLE, FIFO flushed, out_valid=0, mem_rd_en=0, no done.
//   A returning read from a killed issue is discarded.
//  abort wins over a simultaneous start. start while busy is ignored.
// TESTING
//  1 base=0, lane_stride=1, step_stride=8, limit=64, steps=8, ready=1
//    -> 8 beats at T+2..T+9; beat s reads addrs 8s..8s+7; mask=FF; out_last on beat 7; done at T+10.
//  2 base=60, lane_stride=1, step_stride=8, limit=64, steps=1
//    -> mask=0x0F; lanes 4-7 data 0; mem_rd_en=0x0F.
//  3 Same as test 1, out_ready toggled 1010..., then held 0 for 5 cycles
//    -> no beat lost or duplicated; data stable while stalled; mem_rd_en=0 while FIFO full.
//  4 steps=0
//    -> done 1 cycle after start; busy stays 0; out_valid never asserts.
//  5 abort asserted at the 3rd beat of an 8-step job, then restart with base=100
//    -> next cycle busy=0, out_valid=0, no done; new job's first beat reads addr 100 (no stale data).
//  6 base=0x1FFF0, lane_stride=8, step_stride=0, limit=0x1FFFF
//    -> lanes with addr>=limit masked (mask=0x03); no wrap to low addresses.

Source files
------------

// File: rtl/tile_gather_unit.sv
// Multi-lane tile address generator and operand gather.
// Each step issues one banked scratchpad read per in-bounds lane. Out-of-bound
// lanes are zero-filled. The gathered vector is presented on a valid/ready
// stream through a 2-entry output FIFO.

// Per-lane address, bounds check and zero-fill.
module tile_gather_lane #(
  parameter int LANE   = 0,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int W      = 29
) (
  input  logic [W-1:0]      step_base,
  input  logic [ADDR_W-1:0] lane_stride,
  input  logic [ADDR_W-1:0] limit,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_keep,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds,
  output logic [DATA_W-1:0] gathered
);
  localparam logic [W-1:0] LANE_IDX = W'(LANE);

  logic [W-1:0] full_addr;

  // Wide sum so an address past the top of the scratchpad cannot wrap into range.
  assign full_addr = step_base + LANE_IDX * W'(lane_stride);
  assign addr      = full_addr[ADDR_W-1:0];
  assign in_bounds = full_addr < W'(limit);
  assign gathered  = rd_keep ? rd_data : '0;
endmodule

module tile_gather_unit #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [ADDR_W-1:0]         cfg_lane_stride,
  input  logic [ADDR_W-1:0]         cfg_step_stride,
  input  logic [ADDR_W-1:0]         cfg_limit,
  input  logic [CNT_W-1:0]          cfg_steps,
  output logic                      busy,
  output logic                      done,
  output logic [LANES-1:0]          mem_rd_en,
  output logic [LANES*ADDR_W-1:0]   mem_rd_addr,
  input  logic [LANES*DATA_W-1:0]   mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_lane_valid,
  output logic                      out_last,
  output logic [CNT_W-1:0]          out_step
);
  localparam int W = ADDR_W + CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [ADDR_W-1:0] lane_stride_q, step_stride_q, limit_q;
  logic [CNT_W-1:0]  steps_q, issue_cnt_q;
  logic [W-1:0]      step_base_q;

  // FIFO entries are allocated at issue; data lands one cycle later (pend).
  logic [LANES*DATA_W-1:0] ent_data_q [2];
  logic [LANES-1:0]        ent_mask_q [2];
  logic [CNT_W-1:0]        ent_step_q [2];
  logic [1:0]              ent_last_q;
  logic [1:0]              ent_pend_q;
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;

  logic                    issue, is_last, pop, pend_idx;
  logic [LANES-1:0]        lane_ok, rd_keep;
  logic [LANES*DATA_W-1:0] gathered_vec, head_data;

  assign issue    = (state_q == RUN) && (count_q < 2'd2);
  assign is_last  = issue_cnt_q == steps_q - CNT_W'(1);
  assign pend_idx = ent_pend_q[1];
  assign rd_keep  = ent_mask_q[pend_idx];
  assign pop      = out_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tile_gather_lane #(
      .LANE(i), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .W(W)
    ) u_lane (
      .step_base   (step_base_q),
      .lane_stride (lane_stride_q),
      .limit       (limit_q),
      .rd_data     (mem_rd_data[i*DATA_W +: DATA_W]),
      .rd_keep     (rd_keep[i]),
      .addr        (mem_rd_addr[i*ADDR_W +: ADDR_W]),
      .in_bounds   (lane_ok[i]),
      .gathered    (gathered_vec[i*DATA_W +: DATA_W])
    );
  end

  // A head entry still in flight is forwarded straight from the read data.
  assign head_data = ent_pend_q[rd_ptr_q] ? gathered_vec : ent_data_q[rd_ptr_q];

  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign mem_rd_en      = issue ? lane_ok : '0;
  assign out_valid      = count_q != 2'd0;
  assign out_data       = out_valid ? head_data : '0;
  assign out_lane_valid = out_valid ? ent_mask_q[rd_ptr_q] : '0;
  assign out_last       = out_valid && ent_last_q[rd_ptr_q];
  assign out_step       = out_valid ? ent_step_q[rd_ptr_q] : '0;

  // Next-state and done pulse; abort is applied in the register block.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_steps == '0) done_d  = 1'b1;
        else                 state_d = RUN;
      end
      RUN:   if (issue && is_last) state_d = DRAIN;
      DRAIN: if (pop && out_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, job configuration, address walk and FIFO occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      lane_stride_q <= '0;
      step_stride_q <= '0;
      limit_q       <= '0;
      steps_q       <= '0;
      issue_cnt_q   <= '0;
      step_base_q   <= '0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && start) begin
        lane_stride_q <= cfg_lane_stride;
        step_stride_q <= cfg_step_stride;
        limit_q       <= cfg_limit;
        steps_q       <= cfg_steps;
        issue_cnt_q   <= '0;
        step_base_q   <= W'(cfg_base);
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        step_base_q <= step_base_q + W'(step_stride_q);
      end
      count_q <= count_q + 2'(issue) - 2'(pop);
      if (issue) wr_ptr_q <= !wr_ptr_q;
      if (pop)   rd_ptr_q <= !rd_ptr_q;
    end
  end

  // FIFO entry storage: metadata at issue, zero-filled data one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        ent_data_q[k] <= '0;
        ent_mask_q[k] <= '0;
        ent_step_q[k] <= '0;
        ent_last_q[k] <= 1'b0;
        ent_pend_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        ent_pend_q[k] <= !abort && issue && (wr_ptr_q == 1'(k));
        if (ent_pend_q[k]) ent_data_q[k] <= gathered_vec;
        if (issue && wr_ptr_q == 1'(k)) begin
          ent_mask_q[k] <= lane_ok;
          ent_step_q[k] <= issue_cnt_q;
          ent_last_q[k] <= is_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_tile_gather_unit.sv
// Directed bench for tile_gather_unit with a 1-cycle-latency scratchpad model.
module tb_tile_gather_unit;
  localparam int LANES = 8, DATA_W = 8, ADDR_W = 17, CNT_W = 11;

  logic                    clk = 1'b0;
  logic                    rst, start, abort, out_ready;
  logic [ADDR_W-1:0]       cfg_base, cfg_lane_stride, cfg_step_stride, cfg_limit;
  logic [CNT_W-1:0]        cfg_steps;
  logic                    busy, done, out_valid, out_last;
  logic [LANES-1:0]        mem_rd_en, out_lane_valid;
  logic [LANES*ADDR_W-1:0] mem_rd_addr;
  logic [LANES*DATA_W-1:0] mem_rd_data, out_data;
  logic [CNT_W-1:0]        out_step;

  int n_tests = 0, n_fail = 0;

  tile_gather_unit #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_lane_stride(cfg_lane_stride),
    .cfg_step_stride(cfg_step_stride), .cfg_limit(cfg_limit), .cfg_steps(cfg_steps),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane_valid(out_lane_valid), .out_last(out_last),
    .out_step(out_step)
  );

  always #5 clk = ~clk;

  // Scratchpad: word at address a is a[7:0]^3C; unread lanes return EE.
  always @(posedge clk)
    for (int i = 0; i < LANES; i++)
      mem_rd_data[i*DATA_W +: DATA_W] <= mem_rd_en[i] ? (mem_rd_addr[i*ADDR_W +: 8] ^ 8'h3C) : 8'hEE;

  function automatic logic [63:0] exp_vec(input longint base, ls, ss, s, lim);
    logic [63:0] v;
    longint a;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      a = base + s * ss + i * ls;
      if (a < lim) v[i*8 +: 8] = 8'(a) ^ 8'h3C;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives cfg with start for one cycle; returns in the first cycle after start.
  task automatic start_job(input int base, ls, ss, lim, steps);
    cfg_base = ADDR_W'(base); cfg_lane_stride = ADDR_W'(ls);
    cfg_step_stride = ADDR_W'(ss); cfg_limit = ADDR_W'(lim);
    cfg_steps = CNT_W'(steps);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_base = '1; cfg_lane_stride = '1; cfg_step_stride = '1; cfg_limit = '0;
  endtask

  logic [63:0]      held_data;
  logic [CNT_W-1:0] held_step;
  logic             held_v, done_seen;
  int               nxt;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_base = '0; cfg_lane_stride = '0; cfg_step_stride = '0; cfg_limit = '0; cfg_steps = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_en", mem_rd_en, 0);
    chk("rst_addr0", mem_rd_addr[16:0], 0);
    chk("rst_data", out_data, 0);
    rst = 1'b1;
    tick();

    // 1: full-rate 8-step job
    start_job(0, 1, 8, 64, 8);
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8) begin
        chk("t1_en", mem_rd_en, 8'hFF);
        chk("t1_addr0", mem_rd_addr[16:0], 8 * (c - 1));
        chk("t1_addr7", mem_rd_addr[7*17 +: 17], 8 * (c - 1) + 7);
      end
      chk("t1_valid", out_valid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        chk("t1_step", out_step, c - 2);
        chk("t1_data", out_data, exp_vec(0, 1, 8, c - 2, 64));
        chk("t1_mask", out_lane_valid, 8'hFF);
        chk("t1_last", out_last, c == 9);
      end
      chk("t1_busy", busy, c <= 9);
      chk("t1_done", done, c == 10);
      tick();
    end

    // 2: partially out-of-bound single step
    start_job(60, 1, 8, 64, 1);
    chk("t2_en", mem_rd_en, 8'h0F);
    chk("t2_addr0", mem_rd_addr[16:0], 60);
    tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_mask", out_lane_valid, 8'h0F);
    chk("t2_data", out_data, 64'h0000_0000_0302_0100);
    chk("t2_last", out_last, 1);
    tick();
    chk("t2_done", done, 1);
    tick();

    // 3: backpressure with toggling then held-low ready
    start_job(0, 1, 8, 64, 8);
    nxt = 0; held_v = 1'b0; done_seen = 1'b0;
    held_data = '0; held_step = '0;
    for (int c = 1; c <= 60 && !done_seen; c++) begin
      out_ready = (c <= 8) ? ((c % 2) == 1) : (c > 13);
      #1;
      if (held_v) begin
        chk("t3_stable_v", out_valid, 1);
        chk("t3_stable_d", out_data, held_data);
        chk("t3_stable_s", out_step, held_step);
      end
      if (c >= 10 && c <= 13) chk("t3_en_full", mem_rd_en, 0);
      if (out_valid && out_ready) begin
        chk("t3_step", out_step, nxt);
        chk("t3_data", out_data, exp_vec(0, 1, 8, nxt, 64));
        chk("t3_last", out_last, nxt == 7);
        nxt++;
      end
      held_v = out_valid && !out_ready;
      held_data = out_data;
      held_step = out_step;
      tick();
      done_seen = done;
    end
    chk("t3_beats", nxt, 8);
    chk("t3_done_seen", done_seen, 1);
    out_ready = 1'b1;
    tick();

    // 4: zero-step job
    start_job(0, 1, 8, 64, 0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", out_valid, 0);
    tick();
    chk("t4_done_off", done, 0);
    chk("t4_valid2", out_valid, 0);

    // 5: abort on the 3rd beat, then restart at base 100
    start_job(0, 1, 8, 64, 8);
    tick(); tick(); tick();
    chk("t5_third", out_step, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_en", mem_rd_en, 0);
    chk("t5_done", done, 0);
    tick();
    chk("t5_done2", done, 0);
    chk("t5_valid2", out_valid, 0);
    start_job(100, 1, 8, 200, 2);
    chk("t5_addr0", mem_rd_addr[16:0], 100);
    chk("t5_en_new", mem_rd_en, 8'hFF);
    tick();
    chk("t5_step", out_step, 0);
    chk("t5_data", out_data, exp_vec(100, 1, 8, 0, 200));
    repeat (4) tick();

    // 6: top-of-space addresses must not wrap into range
    start_job(32'h1FFF0, 8, 0, 32'h1FFFF, 1);
    chk("t6_en", mem_rd_en, 8'h03);
    chk("t6_addr1", mem_rd_addr[1*17 +: 17], 17'h1FFF8);
    tick();
    chk("t6_mask", out_lane_valid, 8'h03);
    chk("t6_data", out_data, 64'h0000_0000_0000_C4CC);
    tick();
    chk("t6_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
